// File: rtl/phase_ctrl.sv
// phase_ctrl: multi-cycle core sequencer.
// Walks the one-hot phase bus F -> R -> X -> (M) -> W, stalls F and M on the memory
// ready handshake, halts on a decoded halt instruction or on a memory timeout, and keeps
// cycle / retired-instruction counters.
// Optional feature: define SINGLE_STEP_EN to add a `step` input and a PAUSE state after W.
module phase_ctrl #(
  parameter int unsigned WAIT_MAX = 15,  // max stall cycles in F/M before timeout; 0 = off
  parameter int unsigned CYC_W    = 32   // width of the cycles / instret counters
) (
  input  logic             clk,
  input  logic             rst,       // synchronous, active-low
  input  logic             hlt,
  input  logic             skip_m,
  input  logic             mem_rdy,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             mem_req,
  output logic [4:0]       phase,
  output logic             retire,
  output logic             halted,
  output logic             timeout,
  output logic [CYC_W-1:0] cycles,
  output logic [CYC_W-1:0] instret
);

  // Stall counter only needs to reach WAIT_MAX.
  localparam int unsigned WcW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WcW-1:0] WaitMax = WcW'(WAIT_MAX);
  localparam bit          TimeoutEn = (WAIT_MAX != 0);

  typedef enum logic [2:0] {
    StF,
    StR,
    StX,
    StM,
    StW,
    StHalt,
    StPause
  } state_e;

  state_e           state_q, state_d;
  logic [WcW-1:0]   wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic [CYC_W-1:0] instret_q, instret_d;
  logic             expired;

  // Phase bus decode from the current state; HALT and PAUSE drive an all-zero bus.
  always_comb begin
    phase = 5'b00000;
    unique case (state_q)
      StF:     phase = 5'b10000;
      StR:     phase = 5'b01000;
      StX:     phase = 5'b00100;
      StM:     phase = 5'b00010;
      StW:     phase = 5'b00001;
      default: phase = 5'b00000;
    endcase
  end

  // Handshake and status outputs; mem_req is suppressed while reset is asserted so a
  // stalled access is visibly abandoned before the fresh fetch.
  always_comb begin
    mem_req = rst & (phase[4] | phase[1]);
    retire  = phase[0] | (phase[2] & hlt);
    halted  = (state_q == StHalt);
    timeout = timeout_q;
    cycles  = cycles_q;
    instret = instret_q;
  end

  // Next-state logic: phase sequencing, stall counting and timeout detection.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    // A ready in the final allowed stall cycle still wins over the timeout.
    expired   = TimeoutEn && ((state_q == StF) || (state_q == StM)) && !mem_rdy &&
                (wait_q == WaitMax);
    unique case (state_q)
      StF, StM: begin
        if (mem_rdy) begin
          state_d = (state_q == StF) ? StR : StW;
        end else if (expired) begin
          state_d   = StHalt;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WcW'(1);
        end
      end
      StR: state_d = StX;
      StX: begin
        if (hlt) begin
          state_d = StHalt;
        end else if (skip_m) begin
          state_d = StW;
        end else begin
          state_d = StM;
          wait_d  = '0;
        end
      end
      StW: begin
`ifdef SINGLE_STEP_EN
        state_d = StPause;
`else
        state_d = StF;
        wait_d  = '0;
`endif
      end
      StHalt: state_d = StHalt;
      StPause: begin
`ifdef SINGLE_STEP_EN
        if (step) begin
          state_d = StF;
          wait_d  = '0;
        end
`else
        state_d = StF;
        wait_d  = '0;
`endif
      end
      default: begin
        // Unused encoding: restart with a fetch.
        state_d = StF;
        wait_d  = '0;
      end
    endcase
  end

  // Counter next values: cycles runs while the bus is active, instret follows retire.
  always_comb begin
    cycles_d  = cycles_q;
    instret_d = instret_q;
    if (phase != 5'b00000) begin
      cycles_d = cycles_q + CYC_W'(1);
    end
    if (retire) begin
      instret_d = instret_q + CYC_W'(1);
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StF;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      cycles_q  <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      cycles_q  <= cycles_d;
      instret_q <= instret_d;
    end
  end

endmodule
